sram_mem_controller: RTL and testbench

//  Sequences MEM-stage data accesses (LDR/STR) onto an external 16-bit asynchronous SRAM.

---
 rtl/sram_mem_controller_if.sv | 21 ++
 rtl/sram_mem_controller.sv | 112 +++++++++++
 tb/tb_sram_mem_controller.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side MEM-stage bus between the CPU pipeline (master) and the SRAM
// controller (slave). The SRAM pins are separate plain ports on the controller.
interface sram_mem_controller_if;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;

  modport master (
    output mem_r_enable, mem_w_enable, address, wdata,
    input  rdata, ready, stall
  );

  modport slave (
    input  mem_r_enable, mem_w_enable, address, wdata,
    output rdata, ready, stall
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences 32-bit LDR/STR accesses onto a 16-bit async SRAM as two half-word
// accesses (low then high), each held WAIT_CYCLES, stalling the pipeline meanwhile.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_controller_if.slave bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic [1:0]         dbg_state
);

  // Handshake: the MEM stage holds a request (mem_r_enable/mem_w_enable) together
  // with address/wdata; stall stays high until the word completes, then ready
  // pulses for one cycle while stall is low so the pipeline advances exactly once.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int             CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic               op_write_q;

  logic               req;
  logic [SRAM_AW-2:0] word_next;

  assign req = bus.mem_r_enable | bus.mem_w_enable;

  // Byte offset from BASE_ADDR wraps modulo 2^32; byte lane bits are dropped.
  assign word_next = (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            word_q     <= word_next;
            wdata_q    <= bus.wdata;
            op_write_q <= bus.mem_w_enable & ~bus.mem_r_enable;
            cnt        <= '0;
            state      <= S_LOW;
          end
        end
        S_LOW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!op_write_q) rdata_q[15:0] <= sram_rdata;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (!op_write_q) rdata_q[31:16] <= sram_rdata;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // SRAM pins depend only on registered state and latches.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    case (state)
      S_LOW: begin
        sram_addr  = {word_q, 1'b0};
        sram_wdata = wdata_q[15:0];
        sram_we_n  = ~op_write_q;
      end
      S_HIGH: begin
        sram_addr  = {word_q, 1'b1};
        sram_wdata = wdata_q[31:16];
        sram_we_n  = ~op_write_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == S_DONE);
  assign bus.stall = ((state == S_IDLE) && req) || (state == S_LOW) || (state == S_HIGH);
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller (W=2) against a small behavioural SRAM.
`timescale 1ns/1ps
module tb_sram_mem_controller;

  logic        clk;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  sram_mem_controller_if bus ();

  sram_mem_controller #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n (sram_we_n),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural async SRAM: combinational read, write while we_n low
  logic [15:0] sram_mem [0:255] = '{default: 16'h0000};
  assign sram_rdata = sram_mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_wdata;
  end

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd);
    bus.mem_r_enable = rd;
    bus.mem_w_enable = wr;
    bus.address      = addr;
    bus.wdata        = wd;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_checks++;
    if ({bus.ready, bus.stall, sram_we_n} !== 3'b001) begin
      n_fail++; $display("FAIL reset_ctrl: got ready/stall/we_n=%b expected 001", {bus.ready, bus.stall, sram_we_n});
    end
    n_checks++;
    if ({sram_addr, sram_wdata} !== 34'h0) begin
      n_fail++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", sram_addr, sram_wdata);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.stall, bus.ready, sram_we_n, sram_addr} !== {3'b001, 18'h0}) begin
        n_fail++;
        $display("FAIL idle_outputs cyc%0d: got stall=%b ready=%b we_n=%b addr=%h expected 0 0 1 0",
                 i, bus.stall, bus.ready, sram_we_n, sram_addr);
      end
      step();
    end
  endtask

  task automatic test_write;
    logic [1:0]  e_state;
    logic [17:0] e_addr;
    logic [15:0] e_wdata;
    drive_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      e_state = (c == 0) ? 2'd0 : (c <= 2) ? 2'd1 : (c <= 4) ? 2'd2 : 2'd3;
      e_addr  = (c == 3 || c == 4) ? 18'd1 : 18'd0;
      e_wdata = (c == 1 || c == 2) ? 16'hBEEF : (c == 3 || c == 4) ? 16'hDEAD : 16'h0000;
      n_checks++;
      if (dbg_state !== e_state) begin n_fail++; $display("FAIL wr_state cyc%0d: got %0d expected %0d", c, dbg_state, e_state); end
      n_checks++;
      if (sram_addr !== e_addr) begin n_fail++; $display("FAIL wr_addr cyc%0d: got %h expected %h", c, sram_addr, e_addr); end
      n_checks++;
      if (sram_wdata !== e_wdata) begin n_fail++; $display("FAIL wr_wdata cyc%0d: got %h expected %h", c, sram_wdata, e_wdata); end
      n_checks++;
      if (sram_we_n !== !(c >= 1 && c <= 4)) begin n_fail++; $display("FAIL wr_we_n cyc%0d: got %b", c, sram_we_n); end
      n_checks++;
      if (bus.stall !== (c <= 4)) begin n_fail++; $display("FAIL wr_stall cyc%0d: got %b", c, bus.stall); end
      n_checks++;
      if (bus.ready !== (c == 5)) begin n_fail++; $display("FAIL wr_ready cyc%0d: got %b", c, bus.ready); end
    end
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({dbg_state, bus.stall, bus.ready} !== 4'b0000) begin
      n_fail++; $display("FAIL wr_no_reissue: got state=%0d stall=%b ready=%b expected 0 0 0", dbg_state, bus.stall, bus.ready);
    end
    step();
  endtask

  task automatic test_read;
    drive_req(1'b1, 1'b0, 32'd1024, 32'h0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rd_we_n cyc%0d: got %b expected 1", c, sram_we_n); end
      if (c == 1 || c == 3) begin
        n_checks++;
        if (sram_addr !== ((c == 1) ? 18'd0 : 18'd1)) begin n_fail++; $display("FAIL rd_addr cyc%0d: got %h", c, sram_addr); end
      end
      n_checks++;
      if (bus.ready !== (c == 5)) begin n_fail++; $display("FAIL rd_ready cyc%0d: got %b", c, bus.ready); end
    end
    n_checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", bus.rdata); end
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data_held: got %h expected deadbeef", bus.rdata); end
    step();
  endtask

  task automatic test_back_to_back;
    drive_req(1'b0, 1'b1, 32'd1028, 32'h12345678);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 || c == 3) begin
        n_checks++;
        if (sram_addr !== ((c == 1) ? 18'd2 : 18'd3)) begin n_fail++; $display("FAIL b2b_wr_addr cyc%0d: got %h", c, sram_addr); end
      end
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b expected 1", bus.ready); end
    step();
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if ({dbg_state, bus.stall} !== 3'b001) begin n_fail++; $display("FAIL b2b_rd_start: got state=%0d stall=%b", dbg_state, bus.stall); end
      end
      if (c == 1 || c == 3) begin
        n_checks++;
        if ({sram_addr, sram_we_n} !== {((c == 1) ? 18'd2 : 18'd3), 1'b1}) begin
          n_fail++; $display("FAIL b2b_rd_addr cyc%0d: got addr=%h we_n=%b", c, sram_addr, sram_we_n);
        end
      end
    end
    n_checks++;
    if ({bus.ready, bus.rdata} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL b2b_rd_data: got ready=%b rdata=%h expected 1 12345678", bus.ready, bus.rdata);
    end
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_both_enables;
    int we_low;
    we_low = 0;
    drive_req(1'b1, 1'b1, 32'd1032, 32'hAAAA5555);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (sram_we_n !== 1'b1) we_low++;
      if (c == 1) begin
        n_checks++;
        if (sram_addr !== 18'd4) begin n_fail++; $display("FAIL both_addr: got %h expected 4", sram_addr); end
      end
      n_checks++;
      if (bus.ready !== (c == 5)) begin n_fail++; $display("FAIL both_ready cyc%0d: got %b", c, bus.ready); end
    end
    n_checks++;
    if (we_low !== 0) begin n_fail++; $display("FAIL both_we_n: got %0d strobe cycles expected 0", we_low); end
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL both_rdata: got %h expected 0", bus.rdata); end
    n_checks++;
    if ({sram_mem[4], sram_mem[5]} !== 32'h0) begin
      n_fail++; $display("FAIL both_mem: got %h%h expected 0", sram_mem[5], sram_mem[4]);
    end
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset_mid_access;
    drive_req(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
    for (int c = 0; c <= 3; c++) @(negedge clk);
    n_checks++;
    if ({dbg_state, sram_we_n} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_high: got state=%0d we_n=%b expected 2 0", dbg_state, sram_we_n);
    end
    step();
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dbg_state, sram_we_n, bus.stall, bus.ready} !== 5'b00100) begin
      n_fail++; $display("FAIL rstmid_ctrl: got state=%0d we_n=%b stall=%b ready=%b expected 0 1 0 0",
                         dbg_state, sram_we_n, bus.stall, bus.ready);
    end
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 0", bus.rdata); end
    step();
    drive_req(1'b1, 1'b0, 32'd1024, 32'h0);
    for (int c = 0; c <= 5; c++) @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.rdata} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL rstmid_reread: got ready=%b rdata=%h expected 1 cafef00d", bus.ready, bus.rdata);
    end
    step();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_back_to_back();
    test_both_enables();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
